// File: rtl/sub_serial_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_serial_pkg;

    localparam int BW_DATA_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_serial_fsub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module fsub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: o_diff = i_a - i_b - i_bin, one bit per clock, LSB first.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic               i_bin,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_diff,
    output logic               o_bout
);

    localparam int CNT_W = $clog2(BW_DATA) + 1;

    // Handshake: operands transfer on a rising edge with i_valid && o_ready;
    // the result transfers on a rising edge with o_valid && i_ready.
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BW_DATA-1:0] a_sr;
    logic [BW_DATA-1:0] b_sr;
    logic               br;
    logic               d_bit;
    logic               br_next;

    fsub_bit u_fsub_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            br      <= 1'b0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_diff  <= '0;
            o_bout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    if (i_valid && o_ready) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        br      <= i_bin;
                        cnt     <= '0;
                        o_diff  <= '0;
                        o_ready <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Each difference bit enters at the MSB so bit k settles at o_diff[k].
                    o_diff <= {d_bit, o_diff[BW_DATA-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(BW_DATA - 1)) begin
                        o_bout  <= br_next;
                        o_valid <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Directed and randomized bench for sub_serial with a behavioural borrow/difference model.
module tb_sub_serial;

    localparam int BW = 6;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [BW-1:0] i_a;
    logic [BW-1:0] i_b;
    logic          i_bin;
    logic          o_valid;
    logic          i_ready;
    logic [BW-1:0] o_diff;
    logic          o_bout;

    int compared   = 0;
    int mismatched = 0;
    logic [BW:0] exp_q[$];

    sub_serial #(.BW_DATA(BW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_diff  (o_diff),
        .o_bout  (o_bout)
    );

    // clock
    always #5 i_clk = ~i_clk;

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // reference: borrow is bit BW of the (BW+1)-bit wrapped difference
    function automatic logic [BW:0] ref_sub(input int a, input int b, input int bin);
        return (BW+1)'((a - b - bin) & ((1 << (BW + 1)) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: wait for ready, accept, check latency, stall, hand off.
    task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic bin,
                          input logic [BW:0] exp_in, input int stall, input bit noise);
        int n;
        logic [BW:0] exp;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_wait", 32'(n < 50), 1);
        i_a = a;
        i_b = b;
        i_bin = bin;
        i_valid = 1'b1;
        exp_q.push_back(exp_in);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_a = BW'($urandom);
        i_b = BW'($urandom);
        i_bin = 1'($urandom);
        check("ready_low_in_calc", 32'(o_ready), 0);
        n = 0;
        while (!o_valid && n < 50) begin
            if (noise) begin
                i_valid = 1'($urandom);
                i_ready = 1'($urandom);
                i_a = BW'($urandom);
            end
            @(negedge i_clk);
            n++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("latency", 32'(n), 6);
        exp = exp_q.pop_front();
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(o_valid), 1);
            check("stall_ready", 32'(o_ready), 0);
            check("stall_result", 32'({o_bout, o_diff}), 32'(exp));
            if (noise) begin
                i_valid = 1'($urandom);
                i_a = BW'($urandom);
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        check("result", 32'({o_bout, o_diff}), 32'(exp));
        check("valid_at_result", 32'(o_valid), 1);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("valid_after_hs", 32'(o_valid), 0);
        check("ready_after_hs", 32'(o_ready), 1);
        check("result_held_idle", 32'({o_bout, o_diff}), 32'(exp));
    endtask

    initial begin
        logic [BW-1:0] ra;
        logic [BW-1:0] rb;
        logic          rbin;

        // reset block
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a = '0;
        i_b = '0;
        i_bin = 1'b0;
        #2;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_diff", 32'(o_diff), 0);
        check("rst_bout", 32'(o_bout), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // directed spec cases
        run_op(6'd13, 6'd5, 1'b0, 7'd8, 0, 1'b0);
        run_op(6'd5, 6'd13, 1'b0, {1'b1, 6'd56}, 1, 1'b0);
        run_op(6'd0, 6'd0, 1'b1, {1'b1, 6'd63}, 0, 1'b0);
        run_op(6'd63, 6'd63, 1'b0, 7'd0, 0, 1'b0);

        // back-pressure with ignored i_valid pulses
        run_op(6'd40, 6'd17, 1'b1, 7'd22, 10, 1'b1);

        // reset after three CALC steps of 63 - 0
        i_a = 6'd63;
        i_b = 6'd0;
        i_bin = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("partial_diff", 32'(o_diff), 56);
        #1;
        i_rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 1);
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_diff", 32'(o_diff), 0);
        check("midrst_bout", 32'(o_bout), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        run_op(6'd20, 6'd7, 1'b0, 7'd13, 0, 1'b0);

        // randomized operands and result stalls
        for (int k = 0; k < 100; k++) begin
            ra = BW'($urandom);
            rb = BW'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, ref_sub(int'(ra), int'(rb), int'(rbin)),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
